// File: rtl/dmem_mp.sv
// Multi-port data memory: ROM-preloaded RAM with per-port writes, registered reads,
// sticky out-of-range flags and a registered population count over a flag region.
module dmem_mp #(
    parameter int NPORT     = 8,
    parameter int DW        = 16,
    parameter int BASE      = 16,
    parameter int DEPTH     = 32,
    parameter int ROM_DEPTH = 16,
    parameter int FLAG_BASE = 32,
    parameter int FLAG_CNT  = 16,
    parameter int CW        = $clog2(FLAG_CNT + 1),
    parameter int RAW       = $clog2(ROM_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NPORT-1:0]     i_we,
    input  logic [NPORT*32-1:0]  i_addr,
    input  logic [NPORT*32-1:0]  i_wdata,
    output logic [NPORT*32-1:0]  o_rdata,
    output logic [RAW-1:0]       o_rom_addr,
    input  logic [DW-1:0]        i_rom_data,
    output logic                 o_ready,
    output logic [CW-1:0]        o_flag_cnt,
    output logic                 o_flag_all,
    output logic [NPORT-1:0]     o_oor_err,
    input  logic                 i_clr_err
);

    localparam int AW   = $clog2(DEPTH);
    localparam int FOFF = FLAG_BASE - BASE;

    function automatic int clog4(input int n);
        int l;
        int c;
        l = 0;
        c = 1;
        while (c < n) begin
            c = c * 4;
            l++;
        end
        return l;
    endfunction

    function automatic int lvlCnt(input int lvl);
        int c;
        c = FLAG_CNT;
        for (int i = 0; i < lvl; i++) c = (c + 3) / 4;
        return c;
    endfunction

    localparam int NLVL = clog4(FLAG_CNT);

    typedef enum logic [1:0] {S_FILL, S_DRAIN, S_RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic [RAW-1:0]      r_rom_addr, w_rom_addr_nxt;
    logic                w_fill_we;
    logic [AW-1:0]       w_fill_off;
    logic [DW-1:0]       r_mem [DEPTH];
    logic [NPORT*32-1:0] r_rdata;
    logic [NPORT-1:0]    r_oor;
    logic [CW-1:0]       r_flag_cnt;
    logic                r_flag_all;
    logic [CW-1:0]       w_flag_sum;
    logic [6:0]          w_idx [NPORT];
    logic [AW-1:0]       w_off [NPORT];
    logic [NPORT-1:0]    w_inr;
    logic                w_unused;

    assign w_unused   = ^{i_addr, i_wdata};
    assign o_ready    = (r_state == S_RUN);
    assign o_rom_addr = r_rom_addr;
    assign o_rdata    = r_rdata;
    assign o_oor_err  = r_oor;
    assign o_flag_cnt = r_flag_cnt;
    assign o_flag_all = r_flag_all;

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            w_idx[p] = i_addr[p*32+2 +: 7];
            w_inr[p] = (32'(w_idx[p]) >= 32'(BASE)) && (32'(w_idx[p]) < 32'(BASE + DEPTH));
            w_off[p] = AW'(32'(w_idx[p]) - 32'(BASE));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_FILL;
            r_rom_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rom_addr <= w_rom_addr_nxt;
        end
    end

    // ROM data trails its address by a cycle, so each fill write targets the previous address.
    always_comb begin
        w_state_nxt    = r_state;
        w_rom_addr_nxt = r_rom_addr;
        w_fill_we      = 1'b0;
        w_fill_off     = '0;
        case (r_state)
            S_FILL: begin
                if (r_rom_addr == RAW'(ROM_DEPTH - 1)) w_state_nxt = S_DRAIN;
                else w_rom_addr_nxt = r_rom_addr + 1'b1;
                if (r_rom_addr != '0) begin
                    w_fill_we  = 1'b1;
                    w_fill_off = AW'(r_rom_addr) - AW'(1);
                end
            end
            S_DRAIN: begin
                w_fill_we   = 1'b1;
                w_fill_off  = AW'(ROM_DEPTH - 1);
                w_state_nxt = S_RUN;
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Ascending port order makes the highest-numbered port win a same-index collision.
    always_ff @(posedge i_clk) begin
        if (w_fill_we) begin
            r_mem[w_fill_off] <= i_rom_data;
        end else if (o_ready) begin
            for (int p = 0; p < NPORT; p++)
                if (i_we[p] && w_inr[p]) r_mem[w_off[p]] <= i_wdata[p*32 +: DW];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
            r_oor   <= '0;
        end else if (o_ready) begin
            for (int p = 0; p < NPORT; p++) begin
                r_rdata[p*32 +: 32] <= w_inr[p] ? 32'(r_mem[w_off[p]]) : 32'd0;
                r_oor[p]            <= !w_inr[p] || (r_oor[p] && !i_clr_err);
            end
        end else begin
            r_rdata <= '0;
        end
    end

    // Adder tree reduces the flag bits four at a time, in place, one level per pass.
    always_comb begin
        logic [CW-1:0] w_sum [FLAG_CNT];
        logic [CW-1:0] w_acc;
        w_acc = '0;
        for (int k = 0; k < FLAG_CNT; k++) w_sum[k] = CW'(r_mem[FOFF + k][0]);
        for (int lvl = 0; lvl < NLVL; lvl++) begin
            for (int g = 0; g < FLAG_CNT; g++) begin
                if (4 * g < lvlCnt(lvl)) begin
                    w_acc = '0;
                    for (int j = 0; j < 4; j++)
                        if (4 * g + j < lvlCnt(lvl)) w_acc = w_acc + w_sum[4*g + j];
                    w_sum[g] = w_acc;
                end
            end
        end
        w_flag_sum = w_sum[0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flag_cnt <= '0;
            r_flag_all <= 1'b0;
        end else begin
            r_flag_cnt <= w_flag_sum;
            r_flag_all <= (w_flag_sum == CW'(FLAG_CNT));
        end
    end

endmodule

// File: tb/tb_dmem_mp.sv
// Self-checking bench for dmem_mp: directed scenarios plus random traffic, all
// checked every cycle against a word-array model of the memory.
module tb_dmem_mp;

    localparam int NPORT     = 8;
    localparam int BASE      = 16;
    localparam int DEPTH     = 32;
    localparam int ROM_DEPTH = 16;
    localparam int FLAG_BASE = 32;
    localparam int FLAG_CNT  = 16;

    logic                clk = 1'b0;
    logic                rstN = 1'b0;
    logic [NPORT-1:0]    we = '0;
    logic [NPORT*32-1:0] addr = '0;
    logic [NPORT*32-1:0] wdata = '0;
    logic [NPORT*32-1:0] rdata;
    logic [3:0]          romAddr;
    logic [15:0]         romData = '0;
    logic                ready;
    logic [4:0]          flagCnt;
    logic                flagAll;
    logic [NPORT-1:0]    oorErr;
    logic                clrErr = 1'b0;

    logic [15:0] romTbl [ROM_DEPTH];

    int checks = 0;
    int errors = 0;

    logic [15:0] mMem [128];
    bit          mKnown [128];
    logic [31:0] expRd [NPORT];
    bit          expRdKnown [NPORT];
    logic [7:0]  expOor = '0;
    int          expFlag = 0;
    bit          expFlagKnown = 1'b1;
    bit          mReady = 1'b0;
    int          mEdges = 0;

    dmem_mp dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_we       (we),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .o_rdata    (rdata),
        .o_rom_addr (romAddr),
        .i_rom_data (romData),
        .o_ready    (ready),
        .o_flag_cnt (flagCnt),
        .o_flag_all (flagAll),
        .o_oor_err  (oorErr),
        .i_clr_err  (clrErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) romData <= romTbl[romAddr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setPort(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        we[p]             = w;
        addr[p*32 +: 32]  = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic idleInputs();
        for (int p = 0; p < NPORT; p++) setPort(p, 1'b0, 32'h40, $urandom);
        clrErr = 1'b0;
    endtask

    // Memory model: reads see pre-edge contents, writes apply in port order, ROM loads when ready rises.
    initial begin
        forever begin
            logic [6:0]       idx;
            logic [NPORT-1:0] newErr;
            bit               inr;
            int               n;
            bit               allKnown;
            @(posedge clk or negedge rstN);
            if (!rstN) begin
                mReady = 1'b0;
                mEdges = 0;
                expOor = '0;
                expFlag = 0;
                expFlagKnown = 1'b1;
                for (int p = 0; p < NPORT; p++) begin
                    expRd[p] = '0;
                    expRdKnown[p] = 1'b1;
                end
            end else begin
                n = 0;
                allKnown = 1'b1;
                for (int k = 0; k < FLAG_CNT; k++) begin
                    n += int'(mMem[FLAG_BASE + k][0]);
                    allKnown = allKnown && mKnown[FLAG_BASE + k];
                end
                expFlag = n;
                expFlagKnown = allKnown;
                if (mReady) begin
                    newErr = '0;
                    for (int p = 0; p < NPORT; p++) begin
                        idx = addr[p*32+2 +: 7];
                        inr = (int'(idx) >= BASE) && (int'(idx) < BASE + DEPTH);
                        expRd[p] = inr ? {16'h0, mMem[idx]} : 32'h0;
                        expRdKnown[p] = !inr || mKnown[idx];
                        newErr[p] = !inr;
                    end
                    expOor = (clrErr ? 8'h00 : expOor) | newErr;
                    for (int p = 0; p < NPORT; p++) begin
                        idx = addr[p*32+2 +: 7];
                        if (we[p] && int'(idx) >= BASE && int'(idx) < BASE + DEPTH) begin
                            mMem[idx] = wdata[p*32 +: 16];
                            mKnown[idx] = 1'b1;
                        end
                    end
                end else begin
                    for (int p = 0; p < NPORT; p++) begin
                        expRd[p] = '0;
                        expRdKnown[p] = 1'b1;
                    end
                    mEdges++;
                    if (mEdges == ROM_DEPTH + 1) begin
                        mReady = 1'b1;
                        for (int i = 0; i < ROM_DEPTH; i++) begin
                            mMem[BASE + i] = romTbl[i];
                            mKnown[BASE + i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("ready", 32'(ready), 32'(mReady));
        if (!mReady)
            checkOutput("romAddr", 32'(romAddr), (mEdges < ROM_DEPTH - 1) ? mEdges : ROM_DEPTH - 1);
        for (int p = 0; p < NPORT; p++)
            if (expRdKnown[p]) checkOutput($sformatf("rdata%0d", p), rdata[p*32 +: 32], expRd[p]);
        checkOutput("oorErr", 32'(oorErr), 32'(expOor));
        if (expFlagKnown) begin
            checkOutput("flagCnt", 32'(flagCnt), expFlag);
            checkOutput("flagAll", 32'(flagAll), 32'(expFlag == FLAG_CNT));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] a;
        int          idx;
        int          same;

        for (int i = 0; i < ROM_DEPTH; i++) romTbl[i] = 16'hA000 + 16'(i);
        idleInputs();
        applyStimulus(3);
        checkOutput("rstReady", 32'(ready), 32'h0);
        checkOutput("rstRdata0", rdata[31:0], 32'h0);
        checkOutput("rstOor", 32'(oorErr), 32'h0);
        checkOutput("rstFlagCnt", 32'(flagCnt), 32'h0);
        checkOutput("rstRomAddr", 32'(romAddr), 32'h0);

        rstN = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(1);
            if (k == 3) checkOutput("romAddrStep", 32'(romAddr), 32'd3);
            if (k == 16) checkOutput("readyAt16", 32'(ready), 32'h0);
            if (k == 17) checkOutput("readyAt17", 32'(ready), 32'h1);
        end

        for (int p = 0; p < NPORT; p++) setPort(p, 1'b1, 32'((FLAG_BASE + p) * 4), 32'h0);
        applyStimulus(1);
        for (int p = 0; p < NPORT; p++) setPort(p, 1'b1, 32'((FLAG_BASE + 8 + p) * 4), 32'h0);
        applyStimulus(1);
        idleInputs();

        for (int i = 0; i < ROM_DEPTH; i++) begin
            setPort(0, 1'b0, 32'((BASE + i) * 4), $urandom);
            applyStimulus(1);
            checkOutput("initRead", rdata[31:0], 32'h0000A000 + 32'(i));
        end

        for (int p = 0; p < NPORT; p++) setPort(p, 1'b1, 32'h50, 32'hDEAD0000 | (32'h1000 + 32'(p)));
        applyStimulus(1);
        idleInputs();
        setPort(0, 1'b0, 32'h50, 32'h0);
        applyStimulus(1);
        checkOutput("collision", rdata[31:0], 32'h00001007);

        idleInputs();
        setPort(1, 1'b1, 32'h64, 32'hFFFFBEEF);
        setPort(2, 1'b0, 32'h64, 32'h0);
        applyStimulus(1);
        checkOutput("rdwOld", rdata[2*32 +: 32], 32'h0000A009);
        setPort(1, 1'b0, 32'h40, 32'h0);
        applyStimulus(1);
        checkOutput("rdwNew", rdata[2*32 +: 32], 32'h0000BEEF);

        idleInputs();
        for (int k = 0; k < FLAG_CNT; k++) begin
            setPort(0, 1'b1, 32'((FLAG_BASE + k) * 4), 32'h00000001);
            applyStimulus(1);
            checkOutput("flagStep", 32'(flagCnt), 32'(k));
            checkOutput("flagAllLow", 32'(flagAll), 32'h0);
        end
        idleInputs();
        applyStimulus(1);
        checkOutput("flagFull", 32'(flagCnt), 32'd16);
        checkOutput("flagAllHigh", 32'(flagAll), 32'h1);
        setPort(0, 1'b1, 32'(40 * 4), 32'h0);
        applyStimulus(1);
        idleInputs();
        applyStimulus(1);
        checkOutput("flagCleared", 32'(flagCnt), 32'd15);
        checkOutput("flagAllDrop", 32'(flagAll), 32'h0);

        setPort(3, 1'b1, 32'h00, 32'h5555);
        setPort(5, 1'b0, 32'h1FC, 32'h0);
        applyStimulus(1);
        checkOutput("oorRdata5", rdata[5*32 +: 32], 32'h0);
        checkOutput("oorFlags", 32'(oorErr), 32'h28);
        idleInputs();
        clrErr = 1'b1;
        applyStimulus(1);
        checkOutput("oorClear", 32'(oorErr), 32'h0);
        setPort(6, 1'b0, 32'hC0, 32'h0);
        setPort(0, 1'b0, 32'hBC, 32'h0);
        applyStimulus(1);
        checkOutput("oorClrVsNew", 32'(oorErr), 32'h40);
        checkOutput("topWord", rdata[31:0], 32'h1);
        idleInputs();
        setPort(1, 1'b0, 32'h3C, 32'h0);
        applyStimulus(1);
        checkOutput("oorBelowBase", 32'(oorErr), 32'h42);
        idleInputs();
        clrErr = 1'b1;
        applyStimulus(1);
        clrErr = 1'b0;
        checkOutput("oorClear2", 32'(oorErr), 32'h0);

        for (int n = 0; n < 400; n++) begin
            same = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 51) : -1;
            for (int p = 0; p < NPORT; p++) begin
                if (same >= 0) idx = same;
                else if ($urandom_range(0, 19) == 0) idx = $urandom_range(0, 127);
                else idx = $urandom_range(12, 51);
                a = $urandom;
                a[8:2] = idx[6:0];
                setPort(p, ($urandom_range(0, 2) == 0), a, $urandom);
            end
            clrErr = ($urandom_range(0, 9) == 0);
            applyStimulus(1);
        end

        idleInputs();
        for (int i = 0; i < ROM_DEPTH; i++) romTbl[i] = 16'hB000 + 16'(i);
        rstN = 1'b0;
        applyStimulus(1);
        rstN = 1'b1;
        applyStimulus(7);
        rstN = 1'b0;
        #1;
        checkOutput("midRstRomAddr", 32'(romAddr), 32'h0);
        checkOutput("midRstReady", 32'(ready), 32'h0);
        applyStimulus(2);
        rstN = 1'b1;
        checkOutput("restartRomAddr", 32'(romAddr), 32'h0);
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(1);
            if (k == 16) checkOutput("reReadyAt16", 32'(ready), 32'h0);
            if (k == 17) checkOutput("reReadyAt17", 32'(ready), 32'h1);
        end
        for (int i = 0; i < ROM_DEPTH; i++) begin
            setPort(0, 1'b0, 32'((BASE + i) * 4), 32'h0);
            applyStimulus(1);
            checkOutput("reInitRead", rdata[31:0], 32'h0000B000 + 32'(i));
        end
        applyStimulus(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
